legv8_multicycle_control: RTL and testbench
===========================================

Name: legv8_multicycle_control

Overview:
Main control FSM for the multicycle LEGv8 core. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) one instruction at a time. It drives the 2-bit ALUOp consumed by the ALU control block, plus all mux selects and write enables. It handshakes with a variable-latency memory and flags illegal opcodes and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ready per access; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
opcode  in  11  instruction[31:21] from IR.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes current access this cycle.
mem_req  out  1  memory access request.
mem_read  out  1  read access.
mem_write  out  1  write access.
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
ir_write  out  1  load IR.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load if zero.
pc_source  out  1  0 = ALU result, 1 = ALUOut.
alu_src_a  out  1  0 = PC, 1 = reg A.
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = D-format imm, 11 = branch offset<<2.
alu_op  out  2  00 = add, 01 = pass B (CBZ), 10 = R-type via opcode.
reg2loc  out  1  read port 2 = Rt (STUR, CBZ).
reg_write  out  1  register file write.
mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
illegal_op  out  1  one-cycle pulse, unknown opcode.
mem_fault  out  1  one-cycle pulse, memory timeout.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset: rst_n=0 at a clk edge forces IDLE and clears the timeout counter.
  - Every output is 0 in IDLE except reg2loc.
  - Reset mid-operation aborts the instruction. mem_req is 0 from the next cycle.
- IDLE: all outputs 0. Next state is FETCH unconditionally, so the first fetch request appears 1 cycle after rst_n rises.
- All outputs are Moore (decoded from state), with these exceptions:
  - ir_write and pc_write in FETCH are additionally gated by mem_ready.
  - reg2loc is a combinational decode of opcode: 1 for STUR or CBZ, in every state.
- Opcode classes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R class.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx.
  - B 000101xxxxx.
  - Anything else is illegal.
- FETCH:
  - Drives mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
  - If mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise stay.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - R class goes to EXEC_R; LDUR/STUR go to MEM_ADDR; CBZ goes to BR_CBZ; B goes to BR_B.
  - Illegal opcode: illegal_op=1 this cycle, next state FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_req=1, mem_read=1, i_or_d=1. On mem_ready, next state WB_LD.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. On mem_ready, next state FETCH.
- WB_LD: reg_write=1, mem_to_reg=1. Next state FETCH.
- BR_CBZ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Next state FETCH.
- BR_B: pc_write=1, pc_source=1. Next state FETCH.
- Memory handshake:
  - mem_req, mem_read or mem_write, and i_or_d are held stable until the cycle mem_ready=1.
  - mem_ready is ignored in states without mem_req.
  - mem_ready in the first cycle of a wait state means a 1-cycle access.
- Timeout:
  - The counter clears on entry to each memory-wait state and increments each cycle that mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES > 0): mem_fault=1 for one cycle, next state FETCH, no enables asserted.
  - In FETCH, the PC is unchanged, so the fetch is retried.
  - If mem_ready and the timeout coincide, mem_ready wins and no fault is raised.
- CPI: R = 4, LDUR = 5, STUR = 4, CBZ/B = 3, each with 1-cycle memory. Every extra memory wait cycle adds 1.
- Exactly one of mem_read and mem_write is asserted whenever mem_req=1. reg_write is never asserted with mem_req.

Decomposition:
- Shared package legv8_ctrl_pkg contains:
  - Opcode constants and masks for CBZ and B.
  - State enum: IDLE, FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, MEM_WR, WB_LD, BR_CBZ, BR_B.
  - ALUOp and alu_src_b encodings.
  - Opcode class enum: R, LD, ST, CBZ, B, ILL.
- Sub-module legv8_opcode_class is combinational. It maps opcode to class and reg2loc, and is reusable by the immediate generator.

Test Plan:
- Reset, then ADD (opcode 10001011000) with mem_ready tied 1:
  - mem_req rises 1 cycle after rst_n high.
  - State sequence FETCH, DECODE, EXEC_R, WB_R, FETCH.
  - alu_op=10 in EXEC_R, reg_write=1 only in WB_R.
- LDUR with mem_ready delayed 3 cycles in MEM_RD:
  - mem_req, mem_read and i_or_d=1 are held 4 cycles.
  - WB_LD has mem_to_reg=1. Total 8 cycles.
- STUR: reg2loc=1; mem_write=1 only in MEM_WR; returns to FETCH with no reg_write.
- CBZ (10110100101) with zero=1, then with zero=0:
  - BR_CBZ shows alu_op=01, pc_write_cond=1, pc_source=1 both times.
  - pc_write=0 in BR_CBZ.
- Opcode 11111111111: illegal_op pulses 1 cycle in DECODE; the next state is FETCH.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH:
  - mem_fault pulses after 4 wait cycles; FETCH re-requests.
  - Separately, rst_n=0 asserted during MEM_WR: IDLE and mem_req=0 on the next cycle.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multicycle LEGv8 control path:
// opcodes, FSM states, ALU/mux encodings and the per-state control word.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
  localparam logic [10:0] B_MASK    = 11'b11111100000;
  localparam logic [10:0] B_MATCH   = 11'b00010100000;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR,
    MEM_RD, MEM_WR, WB_LD, BR_CBZ, BR_B
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_PASS_B = 2'b01,
    ALU_RTYPE  = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BR   = 2'b11
  } src_b_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL
  } op_class_t;

  typedef struct packed {
    logic    mem_req;
    logic    mem_read;
    logic    mem_write;
    logic    i_or_d;
    logic    ir_write;
    logic    pc_write;
    logic    pc_write_cond;
    logic    pc_source;
    logic    alu_src_a;
    src_b_t  alu_src_b;
    alu_op_t alu_op;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_t;

  // Moore control word for a state; ir_write/pc_write in FETCH are later
  // qualified by mem_ready at the top level.
  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      DECODE:   c.alu_src_b = SRCB_BR;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_RTYPE;
      end
      WB_R:     c.reg_write = 1'b1;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      WB_LD: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      BR_CBZ: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_PASS_B;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      BR_B: begin
        c.pc_write  = 1'b1;
        c.pc_source = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier; also yields reg2loc (read Rt on port 2).
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class,
  output logic        reg2loc
);

  always_comb begin
    op_class = CLS_ILL;
    if ((opcode & CBZ_MASK) == CBZ_MATCH) begin
      op_class = CLS_CBZ;
    end else if ((opcode & B_MASK) == B_MATCH) begin
      op_class = CLS_B;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: op_class = CLS_R;
        OP_LDUR: op_class = CLS_LD;
        OP_STUR: op_class = CLS_ST;
        default: op_class = CLS_ILL;
      endcase
    end
  end

  assign reg2loc = (op_class == CLS_ST) || (op_class == CLS_CBZ);

endmodule

// File: rtl/legv8_multicycle_control.sv
// Main control FSM of the multicycle LEGv8 core: sequences fetch/decode/
// execute/memory/write-back with a variable-latency memory and timeout.
module legv8_multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg2loc,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic        mem_fault
);
  import legv8_ctrl_pkg::*;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state;
  state_t          nxt;
  ctrl_t           ctrl;
  op_class_t       op_class;
  logic [TO_W-1:0] wait_cnt;
  logic            in_wait;
  logic            timeout;
  logic            zero_unused;

  legv8_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class),
    .reg2loc  (reg2loc)
  );

  // The zero flag is consumed by the PC write-enable logic, not the FSM.
  assign zero_unused = zero;

  assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // wait_cnt counts earlier idle cycles, so the fault fires on the
  // TIMEOUT_CYCLES-th consecutive cycle without mem_ready.
  assign timeout = TO_EN && in_wait && !mem_ready && (wait_cnt == TO_LAST);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op_class)
          CLS_R:         nxt = EXEC_R;
          CLS_LD, CLS_ST: nxt = MEM_ADDR;
          CLS_CBZ:       nxt = BR_CBZ;
          CLS_B:         nxt = BR_B;
          default:       nxt = FETCH;
        endcase
      end
      EXEC_R:   nxt = WB_R;
      MEM_ADDR: nxt = (op_class == CLS_LD) ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? WB_LD : (timeout ? FETCH : MEM_RD);
      MEM_WR:   nxt = (mem_ready || timeout) ? FETCH : MEM_WR;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctrl     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode_state(nxt);
      // A timed-out fetch re-enters FETCH without a state change, so the
      // timeout itself must also restart the counter.
      if (timeout || (nxt != state)) begin
        wait_cnt <= '0;
      end else if (in_wait && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign mem_req       = ctrl.mem_req;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign ir_write      = ctrl.ir_write & mem_ready;
  // Only the fetch PC update waits for memory; BR_B has no request.
  assign pc_write      = ctrl.pc_write & (mem_ready | ~ctrl.mem_req);
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign illegal_op    = (state == DECODE) && (op_class == CLS_ILL);
  assign mem_fault     = timeout;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Scoreboard bench for legv8_multicycle_control: stimulus queues the
// hand-computed control word per cycle, a negedge monitor compares.
module tb_legv8_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic        pc_write_cond, pc_source, alu_src_a, reg2loc, reg_write;
  logic        mem_to_reg, illegal_op, mem_fault;
  logic [1:0]  alu_src_b, alu_op;

  legv8_multicycle_control #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg2loc(reg2loc), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: req rd wr iod _ irw pcw pcwc pcs _ srcA _ srcB _ aluop _
  //              reg2loc regw m2r ill fault
  localparam logic [17:0] E_IDLE       = 18'b0000_0000_0_00_00_00000;
  localparam logic [17:0] E_FETCH_WAIT = 18'b1100_0000_0_01_00_00000;
  localparam logic [17:0] E_FETCH_GO   = 18'b1100_1100_0_01_00_00000;
  localparam logic [17:0] E_FETCH_FLT  = 18'b1100_0000_0_01_00_00001;
  localparam logic [17:0] E_DECODE     = 18'b0000_0000_0_11_00_00000;
  localparam logic [17:0] E_DECODE_ILL = 18'b0000_0000_0_11_00_00010;
  localparam logic [17:0] E_EXEC_R     = 18'b0000_0000_1_00_10_00000;
  localparam logic [17:0] E_WB_R       = 18'b0000_0000_0_00_00_01000;
  localparam logic [17:0] E_MEM_ADDR   = 18'b0000_0000_1_10_00_00000;
  localparam logic [17:0] E_MEM_RD     = 18'b1101_0000_0_00_00_00000;
  localparam logic [17:0] E_MEM_WR     = 18'b1011_0000_0_00_00_00000;
  localparam logic [17:0] E_WB_LD      = 18'b0000_0000_0_00_00_01100;
  localparam logic [17:0] E_BR_CBZ     = 18'b0000_0011_1_00_01_00000;
  localparam logic [17:0] E_BR_B       = 18'b0000_0101_0_00_00_00000;
  localparam logic [17:0] R2L          = 18'b0000_0000_0_00_00_10000;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010111111;
  localparam logic [10:0] ILL  = 11'b11111111111;

  typedef struct {
    logic [17:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [17:0] actual;
  assign actual = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
                   pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
                   reg2loc, reg_write, mem_to_reg, illegal_op, mem_fault};

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (actual !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.nm, actual, e.v);
      end
    end
  end

  // Drive this cycle's inputs, queue the control word expected in it,
  // then advance one clock.
  task automatic step(input logic rst, input logic rdy, input logic z,
                      input logic [10:0] op, input logic [17:0] ev,
                      input string nm);
    exp_t e;
    rst_n     = rst;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    e.v  = ev;
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = ADD;
    @(posedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || actual !== E_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", actual, E_IDLE);
    end
    step(0, 1, 0, ADD, E_IDLE, "reset_idle");
    step(1, 1, 0, ADD, E_IDLE, "idle_release");

    step(1, 1, 0, ADD, E_FETCH_GO, "add_fetch");
    step(1, 1, 0, ADD, E_DECODE,   "add_decode");
    step(1, 1, 0, ADD, E_EXEC_R,   "add_exec");
    step(1, 1, 0, ADD, E_WB_R,     "add_wb");

    step(1, 1, 0, LDUR, E_FETCH_GO, "ld_fetch");
    step(1, 1, 0, LDUR, E_DECODE,   "ld_decode");
    step(1, 1, 0, LDUR, E_MEM_ADDR, "ld_addr");
    step(1, 0, 0, LDUR, E_MEM_RD,   "ld_wait1");
    step(1, 0, 0, LDUR, E_MEM_RD,   "ld_wait2");
    step(1, 0, 0, LDUR, E_MEM_RD,   "ld_wait3");
    step(1, 1, 0, LDUR, E_MEM_RD,   "ld_ready_beats_timeout");
    step(1, 1, 0, LDUR, E_WB_LD,    "ld_wb");

    step(1, 1, 0, STUR, E_FETCH_GO | R2L, "st_fetch");
    step(1, 1, 0, STUR, E_DECODE | R2L,   "st_decode");
    step(1, 1, 0, STUR, E_MEM_ADDR | R2L, "st_addr");
    step(1, 1, 0, STUR, E_MEM_WR | R2L,   "st_write");

    step(1, 1, 1, CBZ, E_FETCH_GO | R2L, "cbz1_fetch");
    step(1, 1, 1, CBZ, E_DECODE | R2L,   "cbz1_decode");
    step(1, 1, 1, CBZ, E_BR_CBZ | R2L,   "cbz1_branch");
    step(1, 1, 0, CBZ, E_FETCH_GO | R2L, "cbz0_fetch");
    step(1, 1, 0, CBZ, E_DECODE | R2L,   "cbz0_decode");
    step(1, 1, 0, CBZ, E_BR_CBZ | R2L,   "cbz0_branch");

    step(1, 1, 0, BR, E_FETCH_GO, "b_fetch");
    step(1, 1, 0, BR, E_DECODE,   "b_decode");
    step(1, 1, 0, BR, E_BR_B,     "b_branch");

    step(1, 1, 0, ILL, E_FETCH_GO,   "ill_fetch");
    step(1, 1, 0, ILL, E_DECODE_ILL, "ill_decode");

    step(1, 0, 0, ADD, E_FETCH_WAIT, "to_wait1");
    step(1, 0, 0, ADD, E_FETCH_WAIT, "to_wait2");
    step(1, 0, 0, ADD, E_FETCH_WAIT, "to_wait3");
    n_checks++;
    if (mem_fault !== 1'b1 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL expired_wait: mem_fault=%b mem_req=%b expected 1 1",
               mem_fault, mem_req);
    end
    step(1, 0, 0, ADD, E_FETCH_FLT,  "to_fault");
    step(1, 0, 0, ADD, E_FETCH_WAIT, "retry_wait1");
    step(1, 0, 0, ADD, E_FETCH_WAIT, "retry_wait2");
    step(1, 0, 0, ADD, E_FETCH_WAIT, "retry_wait3");
    step(1, 1, 0, ADD, E_FETCH_GO,   "retry_ready_beats_timeout");
    step(1, 1, 0, ADD, E_DECODE,     "retry_decode");
    step(1, 1, 0, ADD, E_EXEC_R,     "retry_exec");
    step(1, 1, 0, ADD, E_WB_R,       "retry_wb");

    step(1, 1, 0, STUR, E_FETCH_GO | R2L, "rst_st_fetch");
    step(1, 1, 0, STUR, E_DECODE | R2L,   "rst_st_decode");
    step(1, 1, 0, STUR, E_MEM_ADDR | R2L, "rst_st_addr");
    step(0, 0, 0, STUR, E_MEM_WR | R2L,   "rst_in_memwr");
    step(1, 1, 0, STUR, E_IDLE | R2L,     "rst_abort_idle");
    step(1, 1, 0, STUR, E_FETCH_GO | R2L, "rst_refetch");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
